// File: rtl/d_input_debounce_sync.sv
// d_input_debounce_sync
// Conditions a raw asynchronous line (switch/data) for the level-triggered D flip-flop:
// a multi-flop synchroniser, a two-state debounce qualifier that accepts a new level only
// after STABLE_CYCLES consecutive differing samples, registered rise/fall pulses and a busy
// flag that is high while a candidate change is being qualified.
// Optional feature: define DEBOUNCE_GLITCH_CNT_EN to add the saturating glitch_cnt output,
// which counts every rejected (bounced) change and is cleared only by rst_n.
module d_input_debounce_sync #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 16,
   parameter int CNT_W         = 8,
   parameter int GLITCH_W      = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                din,
   output logic                d_out,
   output logic                rise_pulse,
   output logic                fall_pulse,
   output logic                busy
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

   // Parameter legality is checked at elaboration so a bad build never reaches silicon.
   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("d_input_debounce_sync: SYNC_STAGES must be >= 2");
   end
   if (STABLE_CYCLES < 2) begin : g_chk_stable_min
      $error("d_input_debounce_sync: STABLE_CYCLES must be >= 2");
   end
   if (64'(STABLE_CYCLES) >= (64'd1 << CNT_W)) begin : g_chk_stable_max
      $error("d_input_debounce_sync: STABLE_CYCLES must be < 2**CNT_W");
   end

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CHECK = 1'b1
   } state_t;

   // Terminal count: the sample that reaches this value is the STABLE_CYCLES-th agreeing one.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   s_s;

   state_t                 state_q;
   state_t                 state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   d_out_q;
   logic                   d_out_d;
   logic                   rise_q;
   logic                   rise_d;
   logic                   fall_q;
   logic                   fall_d;
   logic                   busy_q;
   logic                   busy_d;

   // Synchroniser shift: din enters stage 0, the last stage is the clean sample.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
   end

   assign s_s = sync_q[SYNC_STAGES-1];

   // Synchroniser flops; no logic between stages so metastability has a full cycle to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_q <= sync_d;
      end
   end

   // Qualifier next-state: compare the synchronised sample against the registered level.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      d_out_d = d_out_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         ST_IDLE: begin
            if (s_s != d_out_q) begin
               state_d = ST_CHECK;
               cnt_d   = CNT_W'(1);
               busy_d  = 1'b1;
            end else begin
               cnt_d   = {CNT_W{1'b0}};
               busy_d  = 1'b0;
            end
         end
         ST_CHECK: begin
            if (s_s == d_out_q) begin
               // A single agreeing sample abandons the candidate: bounce rejected.
               state_d = ST_IDLE;
               cnt_d   = {CNT_W{1'b0}};
               busy_d  = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = {CNT_W{1'b0}};
               busy_d  = 1'b0;
               d_out_d = ~d_out_q;
               rise_d  = ~d_out_q;
               fall_d  = d_out_q;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               busy_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            busy_d  = 1'b0;
         end
      endcase
   end

   // Qualifier FSM state and all of its registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= {CNT_W{1'b0}};
         d_out_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         d_out_q <= d_out_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
         busy_q  <= busy_d;
      end
   end

   assign d_out      = d_out_q;
   assign rise_pulse = rise_q;
   assign fall_pulse = fall_q;
   assign busy       = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic                glitch_s;
   logic [GLITCH_W-1:0] glitch_q;
   logic [GLITCH_W-1:0] glitch_d;

   // Saturating count of rejected candidates; stays at all-ones once full.
   always_comb begin
      glitch_s = (state_q == ST_CHECK) && (s_s == d_out_q);
      if (glitch_s && (glitch_q != {GLITCH_W{1'b1}})) begin
         glitch_d = glitch_q + GLITCH_W'(1);
      end else begin
         glitch_d = glitch_q;
      end
   end

   // Glitch counter register, cleared only by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         glitch_q <= {GLITCH_W{1'b0}};
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_d_input_debounce_sync.sv
// Self-checking bench for d_input_debounce_sync (SYNC_STAGES=2, STABLE_CYCLES=4, GLITCH_W=2).
// Stimulus pushes each expected pulse (kind + cycle) into a queue; a negedge monitor pops and
// compares whenever the DUT emits a pulse. Level/busy checks are made directly from the bench.
module tb_d_input_debounce_sync;

   localparam int SYNC   = 2;
   localparam int STABLE = 4;
   localparam int GW     = 2;
   localparam int LAT    = SYNC + STABLE; // drive at cycle c -> pulse seen at cycle c+LAT

   logic clk;
   logic rst_n;
   logic din;
   logic d_out;
   logic rise_pulse;
   logic fall_pulse;
   logic busy;
   logic [GW-1:0] glitch_cnt;

   typedef struct {
      logic rise;
      int   cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc;
   int   n_total;
   int   n_bad;
   logic prev_pulse;
   logic prev_busy;

   d_input_debounce_sync #(
      .SYNC_STAGES  (SYNC),
      .STABLE_CYCLES(STABLE),
      .CNT_W        (8),
      .GLITCH_W     (GW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .d_out     (d_out),
      .rise_pulse(rise_pulse),
      .fall_pulse(fall_pulse),
      .busy      (busy)
`ifdef DEBOUNCE_GLITCH_CNT_EN
      ,
      .glitch_cnt(glitch_cnt)
`endif
   );

`ifndef DEBOUNCE_GLITCH_CNT_EN
   assign glitch_cnt = '0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter used to timestamp expected pulses.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic push_exp(input logic rise, input int at_cyc);
      exp_t e;
      e.rise = rise;
      e.cyc  = at_cyc;
      exp_q.push_back(e);
   endtask

   // Pulse monitor: every pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rise_pulse || fall_pulse) begin
            check_val("pulse_excl", {31'd0, rise_pulse & fall_pulse}, 32'd0);
            check_val("pulse_gap", {31'd0, prev_pulse}, 32'd0);
            if (exp_q.size() == 0) begin
               check_val("unexp_pulse", {30'd0, rise_pulse, fall_pulse}, 32'd0);
            end else begin
               check_val("pulse_kind", {31'd0, rise_pulse}, {31'd0, exp_q[0].rise});
               check_val("pulse_cyc", cyc, exp_q[0].cyc);
               check_val("pulse_level", {31'd0, d_out}, {31'd0, exp_q[0].rise});
               void'(exp_q.pop_front());
            end
         end
         prev_pulse <= rise_pulse | fall_pulse;
      end else begin
         prev_pulse <= 1'b0;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      n_total   = 0;
      n_bad     = 0;
      prev_busy = 1'b0;

      // 1: reset held with din=1
      rst_n = 1'b0;
      din   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_d_out", {31'd0, d_out}, 32'd0);
      check_val("rst_rise", {31'd0, rise_pulse}, 32'd0);
      check_val("rst_fall", {31'd0, fall_pulse}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check_val("rst_glitch", {30'd0, glitch_cnt}, 32'd0);
`endif
      @(negedge clk);
      din = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 2: clean rise, then clean fall
      c   = cyc;
      din = 1'b1;
      push_exp(1'b1, c + LAT);
      wait_until(c + 2);
      check_val("rise_busy_early", {31'd0, busy}, 32'd0);
      wait_until(c + 3);
      check_val("rise_busy_on", {31'd0, busy}, 32'd1);
      wait_until(c + 5);
      check_val("rise_d_before", {31'd0, d_out}, 32'd0);
      check_val("rise_busy_hold", {31'd0, busy}, 32'd1);
      wait_until(c + 6);
      check_val("rise_d_after", {31'd0, d_out}, 32'd1);
      check_val("rise_busy_off", {31'd0, busy}, 32'd0);
      wait_until(c + 8);

      c   = cyc;
      din = 1'b0;
      push_exp(1'b0, c + LAT);
      wait_until(c + 5);
      check_val("fall_d_before", {31'd0, d_out}, 32'd1);
      wait_until(c + 6);
      check_val("fall_d_after", {31'd0, d_out}, 32'd0);
      wait_until(c + 8);

      // 3: bounce 1,1,0 then steady 1 -> qualification restarts
      c   = cyc;
      din = 1'b1;
      wait_until(c + 2);
      din = 1'b0;
      wait_until(c + 3);
      din = 1'b1;
      push_exp(1'b1, c + 3 + LAT);
      wait_until(c + 5);
      check_val("bounce_busy_drop", {31'd0, busy}, 32'd0);
      wait_until(c + 8);
      check_val("bounce_d_before", {31'd0, d_out}, 32'd0);
      wait_until(c + 9);
      check_val("bounce_d_after", {31'd0, d_out}, 32'd1);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check_val("bounce_glitch", {30'd0, glitch_cnt}, 32'd1);
`endif
      wait_until(c + 11);

      // 4: async reset while qualifying a fall: d_out forced 0 without a clock edge
      c   = cyc;
      din = 1'b0;
      wait_until(c + 4);
      check_val("midchk_busy", {31'd0, busy}, 32'd1);
      check_val("midchk_d", {31'd0, d_out}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("async_d_out", {31'd0, d_out}, 32'd0);
      check_val("async_busy", {31'd0, busy}, 32'd0);
      check_val("async_fall", {31'd0, fall_pulse}, 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check_val("async_glitch", {30'd0, glitch_cnt}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check_val("post_rst_d", {31'd0, d_out}, 32'd0);
      check_val("post_rst_busy", {31'd0, busy}, 32'd0);

      // 5: five single-cycle pulses are all rejected; counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         din = 1'b1;
         @(negedge clk);
         din = 1'b0;
         repeat (4) @(negedge clk);
      end
      check_val("sat_d_out", {31'd0, d_out}, 32'd0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check_val("sat_glitch", {30'd0, glitch_cnt}, 32'd3);
`endif

      // 6: din toggling every cycle -> busy alternates, d_out never moves
      for (int i = 0; i < 20; i++) begin
         din = ~din;
         @(negedge clk);
         if (i >= 4) begin
            check_val("toggle_busy", {31'd0, busy}, {31'd0, ~prev_busy});
         end
         prev_busy = busy;
      end
      din = 1'b0;
      repeat (5) @(negedge clk);
      check_val("toggle_d_out", {31'd0, d_out}, 32'd0);
      check_val("toggle_busy_end", {31'd0, busy}, 32'd0);

      // 7: boundary - STABLE-1 samples rejected, exactly STABLE samples accepted
      c   = cyc;
      din = 1'b1;
      wait_until(c + 3);
      din = 1'b0;
      wait_until(c + 7);
      check_val("short_d_out", {31'd0, d_out}, 32'd0);
      wait_until(c + 10);
      c   = cyc;
      din = 1'b1;
      push_exp(1'b1, c + LAT);
      push_exp(1'b0, c + 4 + LAT);
      wait_until(c + 4);
      din = 1'b0;
      wait_until(c + 6);
      check_val("exact_d_high", {31'd0, d_out}, 32'd1);
      wait_until(c + 10);
      check_val("exact_d_low", {31'd0, d_out}, 32'd0);
      wait_until(c + 14);

      check_val("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
